// File: rtl/fractal_sync_1d_req_queue.sv
// rtl/fractal_sync_1d_req_queue.sv - per-port request queue ahead of the 1D fractal-sync RF
// Issues the head entry as a local/remote check and consumes, drops or recirculates it on the RF verdict.
module fractal_sync_1d_req_queue #(
  parameter int unsigned FIFO_DEPTH  = 4,
  parameter int unsigned LEVEL_WIDTH = 1,
  parameter int unsigned ID_WIDTH    = 1,
  parameter int unsigned SD_WIDTH    = 2,
  parameter int unsigned CNT_WIDTH   = $clog2(FIFO_DEPTH+1)
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   req_valid_i,
  output logic                   req_ready_o,
  input  logic [LEVEL_WIDTH-1:0] req_level_i,
  input  logic [ID_WIDTH-1:0]    req_id_i,
  input  logic [SD_WIDTH-1:0]    req_sd_i,
  input  logic                   req_local_i,
  output logic [LEVEL_WIDTH-1:0] level_o,
  output logic [ID_WIDTH-1:0]    id_o,
  output logic [SD_WIDTH-1:0]    sd_o,
  output logic                   check_local_o,
  output logic                   check_remote_o,
  input  logic                   issue_en_i,
  input  logic                   bypass_i,
  input  logic                   ignore_i,
  output logic [CNT_WIDTH-1:0]   count_o,
  output logic                   empty_o,
  output logic                   full_o,
  output logic [7:0]             replay_cnt_o,
  output logic [7:0]             drop_cnt_o
);

  localparam int unsigned PTR_WIDTH   = $clog2(FIFO_DEPTH);
  localparam int unsigned ENTRY_WIDTH = LEVEL_WIDTH + ID_WIDTH + SD_WIDTH + 1;

  typedef logic [PTR_WIDTH-1:0]   ptr_t;
  typedef logic [ENTRY_WIDTH-1:0] entry_t;

  // Pointers wrap explicitly so non-power-of-two depths work.
  function automatic ptr_t ptr_inc(input ptr_t p);
    if (p == ptr_t'(FIFO_DEPTH - 1)) return '0;
    return p + ptr_t'(1);
  endfunction

  entry_t               mem_q [FIFO_DEPTH];
  entry_t               mem_d [FIFO_DEPTH];
  ptr_t                 rd_ptr_q, rd_ptr_d;
  ptr_t                 wr_ptr_q, wr_ptr_d;
  ptr_t                 push_slot;
  logic [CNT_WIDTH-1:0] count_q, count_d;
  logic [7:0]           replay_cnt_q, replay_cnt_d;
  logic [7:0]           drop_cnt_q, drop_cnt_d;

  entry_t head;
  logic   empty, issue, push, recirc, drop;

  assign head    = mem_q[rd_ptr_q];
  assign empty   = (count_q == '0);
  assign issue   = !empty && issue_en_i;
  assign drop    = issue && ignore_i;
  assign recirc  = issue && !ignore_i && bypass_i;
  assign push    = req_valid_i && req_ready_o;

  assign req_ready_o    = (count_q < CNT_WIDTH'(FIFO_DEPTH));
  assign full_o         = (count_q == CNT_WIDTH'(FIFO_DEPTH));
  assign empty_o        = empty;
  assign count_o        = count_q;
  assign replay_cnt_o   = replay_cnt_q;
  assign drop_cnt_o     = drop_cnt_q;
  assign check_local_o  = issue && head[0];
  assign check_remote_o = issue && !head[0];
  assign sd_o           = empty ? '0 : head[SD_WIDTH:1];
  assign id_o           = empty ? '0 : head[SD_WIDTH+ID_WIDTH:SD_WIDTH+1];
  assign level_o        = empty ? '0 : head[ENTRY_WIDTH-1 -: LEVEL_WIDTH];

  // A recirculated head takes the tail slot first; a same-cycle request lands right behind it.
  assign push_slot = recirc ? ptr_inc(wr_ptr_q) : wr_ptr_q;

  always_comb begin
    mem_d        = mem_q;
    rd_ptr_d     = rd_ptr_q;
    wr_ptr_d     = wr_ptr_q;
    count_d      = count_q;
    replay_cnt_d = replay_cnt_q;
    drop_cnt_d   = drop_cnt_q;

    if (issue) begin
      rd_ptr_d = ptr_inc(rd_ptr_q);
    end
    if (recirc) begin
      mem_d[wr_ptr_q] = head;
      replay_cnt_d    = replay_cnt_q + 8'd1;
    end
    if (drop) begin
      drop_cnt_d = drop_cnt_q + 8'd1;
    end
    if (push) begin
      mem_d[push_slot] = {req_level_i, req_id_i, req_sd_i, req_local_i};
    end
    if (recirc || push) begin
      wr_ptr_d = (recirc && push) ? ptr_inc(push_slot) : ptr_inc(wr_ptr_q);
    end

    if (push && !(issue && !recirc)) begin
      count_d = count_q + CNT_WIDTH'(1);
    end else if (!push && issue && !recirc) begin
      count_d = count_q - CNT_WIDTH'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    mem_q <= mem_d;
    if (rst_i) begin
      rd_ptr_q     <= '0;
      wr_ptr_q     <= '0;
      count_q      <= '0;
      replay_cnt_q <= '0;
      drop_cnt_q   <= '0;
    end else begin
      rd_ptr_q     <= rd_ptr_d;
      wr_ptr_q     <= wr_ptr_d;
      count_q      <= count_d;
      replay_cnt_q <= replay_cnt_d;
      drop_cnt_q   <= drop_cnt_d;
    end
  end

endmodule

// File: tb/tb_fractal_sync_1d_req_queue.sv
// tb/tb_fractal_sync_1d_req_queue.sv - self-checking bench for fractal_sync_1d_req_queue
// Directed scenarios plus randomized traffic against a queue-based reference model.
module tb_fractal_sync_1d_req_queue;

  localparam int DEPTH = 4;
  localparam int LW    = 1;
  localparam int IW    = 4;
  localparam int SW    = 2;
  localparam int CW    = $clog2(DEPTH + 1);

  typedef struct packed {
    logic [LW-1:0] lvl;
    logic [IW-1:0] id;
    logic [SW-1:0] sd;
    logic          loc;
  } ent_t;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          req_valid = 1'b0;
  logic          req_ready;
  logic [LW-1:0] req_level = '0;
  logic [IW-1:0] req_id = '0;
  logic [SW-1:0] req_sd = '0;
  logic          req_local = 1'b0;
  logic [LW-1:0] level_o;
  logic [IW-1:0] id_o;
  logic [SW-1:0] sd_o;
  logic          check_local, check_remote;
  logic          issue_en = 1'b0;
  logic          bypass = 1'b0;
  logic          ignore = 1'b0;
  logic [CW-1:0] count_o;
  logic          empty_o, full_o;
  logic [7:0]    replay_cnt, drop_cnt;

  int   checks = 0;
  int   errors = 0;
  ent_t mq[$];
  int   m_replay = 0;
  int   m_drop = 0;

  fractal_sync_1d_req_queue #(
    .FIFO_DEPTH(DEPTH), .LEVEL_WIDTH(LW), .ID_WIDTH(IW), .SD_WIDTH(SW)
  ) dut (
    .clk_i(clk), .rst_i(rst),
    .req_valid_i(req_valid), .req_ready_o(req_ready),
    .req_level_i(req_level), .req_id_i(req_id), .req_sd_i(req_sd), .req_local_i(req_local),
    .level_o(level_o), .id_o(id_o), .sd_o(sd_o),
    .check_local_o(check_local), .check_remote_o(check_remote),
    .issue_en_i(issue_en), .bypass_i(bypass), .ignore_i(ignore),
    .count_o(count_o), .empty_o(empty_o), .full_o(full_o),
    .replay_cnt_o(replay_cnt), .drop_cnt_o(drop_cnt)
  );

  always #5 clk = ~clk;

  // Reference model advances with the clock edge using the inputs currently driven.
  task automatic tick();
    ent_t h;
    bit   iss, psh;
    iss = (mq.size() > 0) && issue_en;
    psh = req_valid && (mq.size() < DEPTH);
    if (rst) begin
      mq.delete();
      m_replay = 0;
      m_drop   = 0;
    end else begin
      if (iss) begin
        h = mq.pop_front();
        if (ignore) m_drop = (m_drop + 1) % 256;
        else if (bypass) begin
          mq.push_back(h);
          m_replay = (m_replay + 1) % 256;
        end
      end
      if (psh) mq.push_back(ent_t'{req_level, req_id, req_sd, req_local});
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    req_valid = 0; issue_en = 0; bypass = 0; ignore = 0; rst = 0;
    req_level = '0; req_id = '0; req_sd = '0; req_local = 0;
  endtask

  task automatic push(input int id, input bit loc);
    req_valid = 1; req_id = IW'(id); req_local = loc;
    tick();
    req_valid = 0;
  endtask

  task automatic test_reset();
    idle();
    rst = 1;
    tick();
    rst = 0; issue_en = 1;
    #1;
    checks += 9;
    if (count_o !== 0) begin errors++; $display("FAIL reset_count got %0d want 0", count_o); end
    if (empty_o !== 1) begin errors++; $display("FAIL reset_empty got %0b want 1", empty_o); end
    if (full_o !== 0) begin errors++; $display("FAIL reset_full got %0b want 0", full_o); end
    if (req_ready !== 1) begin errors++; $display("FAIL reset_ready got %0b want 1", req_ready); end
    if (check_local !== 0 || check_remote !== 0) begin
      errors++; $display("FAIL reset_check got %0b%0b want 00", check_local, check_remote);
    end
    if (id_o !== 0) begin errors++; $display("FAIL reset_id got %0d want 0", id_o); end
    if (level_o !== 0 || sd_o !== 0) begin
      errors++; $display("FAIL reset_fields got %0d/%0d want 0/0", level_o, sd_o);
    end
    if (replay_cnt !== 0) begin errors++; $display("FAIL reset_replay got %0d want 0", replay_cnt); end
    if (drop_cnt !== 0) begin errors++; $display("FAIL reset_drop got %0d want 0", drop_cnt); end
    idle();
  endtask

  task automatic test_single();
    idle();
    issue_en = 1;
    push(1, 1);
    #1;
    checks += 4;
    if (count_o !== 1) begin errors++; $display("FAIL single_count got %0d want 1", count_o); end
    if (check_local !== 1) begin errors++; $display("FAIL single_local got %0b want 1", check_local); end
    if (check_remote !== 0) begin errors++; $display("FAIL single_remote got %0b want 0", check_remote); end
    if (id_o !== 1) begin errors++; $display("FAIL single_id got %0d want 1", id_o); end
    tick();
    checks += 2;
    if (count_o !== 0) begin errors++; $display("FAIL single_consume got %0d want 0", count_o); end
    if (empty_o !== 1) begin errors++; $display("FAIL single_empty got %0b want 1", empty_o); end
    idle();
  endtask

  task automatic test_fill();
    idle();
    for (int i = 0; i < DEPTH; i++) push(i, 0);
    checks += 2;
    if (full_o !== 1) begin errors++; $display("FAIL fill_full got %0b want 1", full_o); end
    if (req_ready !== 0) begin errors++; $display("FAIL fill_ready got %0b want 0", req_ready); end
    push(4, 0);
    checks++;
    if (count_o !== CW'(DEPTH)) begin errors++; $display("FAIL fill_reject got %0d want %0d", count_o, DEPTH); end
    issue_en = 1;
    for (int i = 0; i < DEPTH; i++) begin
      #1;
      checks += 2;
      if (id_o !== IW'(i)) begin errors++; $display("FAIL drain_order got %0d want %0d", id_o, i); end
      if (check_remote !== 1) begin errors++; $display("FAIL drain_remote got %0b want 1", check_remote); end
      tick();
    end
    checks++;
    if (empty_o !== 1) begin errors++; $display("FAIL drain_empty got %0b want 1", empty_o); end
    idle();
  endtask

  task automatic test_bypass();
    idle();
    push(5, 1);
    push(6, 1);
    issue_en = 1; bypass = 1;
    #1;
    checks += 2;
    if (id_o !== 5) begin errors++; $display("FAIL bypass_first got %0d want 5", id_o); end
    if (count_o !== 2) begin errors++; $display("FAIL bypass_cnt0 got %0d want 2", count_o); end
    tick();
    bypass = 0;
    #1;
    checks += 3;
    if (id_o !== 6) begin errors++; $display("FAIL bypass_second got %0d want 6", id_o); end
    if (count_o !== 2) begin errors++; $display("FAIL bypass_cnt1 got %0d want 2", count_o); end
    if (replay_cnt !== 1) begin errors++; $display("FAIL bypass_replay got %0d want 1", replay_cnt); end
    tick();
    checks += 2;
    if (id_o !== 5) begin errors++; $display("FAIL bypass_third got %0d want 5", id_o); end
    if (count_o !== 1) begin errors++; $display("FAIL bypass_cnt2 got %0d want 1", count_o); end
    tick();
    idle();
  endtask

  task automatic test_ignore_priority();
    idle();
    push(2, 0);
    issue_en = 1; bypass = 1; ignore = 1;
    tick();
    idle();
    #1;
    checks += 3;
    if (drop_cnt !== 1) begin errors++; $display("FAIL ignore_drop got %0d want 1", drop_cnt); end
    if (replay_cnt !== 1) begin errors++; $display("FAIL ignore_replay got %0d want 1", replay_cnt); end
    if (empty_o !== 1) begin errors++; $display("FAIL ignore_empty got %0b want 1", empty_o); end
  endtask

  task automatic test_push_bypass();
    int exp1[4] = '{10, 11, 7, 9};
    int exp2[4] = '{1, 2, 3, 7};
    idle();
    push(7, 1); push(10, 1); push(11, 1);
    issue_en = 1; bypass = 1; req_valid = 1; req_id = 9; req_local = 1;
    tick();
    idle(); issue_en = 1;
    #1;
    checks += 2;
    if (count_o !== 4) begin errors++; $display("FAIL pb_count got %0d want 4", count_o); end
    if (replay_cnt !== 2) begin errors++; $display("FAIL pb_replay got %0d want 2", replay_cnt); end
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (id_o !== IW'(exp1[i])) begin errors++; $display("FAIL pb_order got %0d want %0d", id_o, exp1[i]); end
      tick();
    end
    idle();
    push(7, 0); push(1, 0); push(2, 0); push(3, 0);
    issue_en = 1; bypass = 1; req_valid = 1; req_id = 9;
    #1;
    checks++;
    if (req_ready !== 0) begin errors++; $display("FAIL pbfull_ready got %0b want 0", req_ready); end
    tick();
    idle(); issue_en = 1;
    #1;
    checks++;
    if (count_o !== 4) begin errors++; $display("FAIL pbfull_count got %0d want 4", count_o); end
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (id_o !== IW'(exp2[i])) begin errors++; $display("FAIL pbfull_order got %0d want %0d", id_o, exp2[i]); end
      tick();
    end
    checks++;
    if (empty_o !== 1) begin errors++; $display("FAIL pbfull_empty got %0b want 1", empty_o); end
    idle();
  endtask

  task automatic test_reset_mid();
    idle();
    push(3, 1);
    req_valid = 1; req_id = 4; rst = 1; issue_en = 1; ignore = 1;
    tick();
    idle(); issue_en = 1;
    #1;
    checks += 5;
    if (count_o !== 0) begin errors++; $display("FAIL rmid_count got %0d want 0", count_o); end
    if (empty_o !== 1 || full_o !== 0) begin
      errors++; $display("FAIL rmid_flags got e%0b f%0b want e1 f0", empty_o, full_o);
    end
    if (check_local !== 0 || check_remote !== 0) begin
      errors++; $display("FAIL rmid_check got %0b%0b want 00", check_local, check_remote);
    end
    if (replay_cnt !== 0) begin errors++; $display("FAIL rmid_replay got %0d want 0", replay_cnt); end
    if (drop_cnt !== 0) begin errors++; $display("FAIL rmid_drop got %0d want 0", drop_cnt); end
    idle();
  endtask

  task automatic test_random();
    ent_t h;
    bit   nonempty;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      req_valid = ($urandom_range(99) < 60);
      req_level = LW'($urandom);
      req_id    = IW'($urandom);
      req_sd    = SW'($urandom);
      req_local = 1'($urandom);
      issue_en  = ($urandom_range(99) < 70);
      bypass    = ($urandom_range(99) < 30);
      ignore    = ($urandom_range(99) < 15);
      rst       = ($urandom_range(999) < 5);
      #1;
      nonempty = (mq.size() > 0);
      h = nonempty ? mq[0] : '0;
      checks += 8;
      if (count_o !== CW'(mq.size())) begin
        errors++; $display("FAIL rnd_count cyc %0d got %0d want %0d", cyc, count_o, mq.size());
      end
      if (empty_o !== !nonempty || full_o !== (mq.size() == DEPTH)) begin
        errors++; $display("FAIL rnd_flags cyc %0d got e%0b f%0b size %0d", cyc, empty_o, full_o, mq.size());
      end
      if (req_ready !== (mq.size() < DEPTH)) begin
        errors++; $display("FAIL rnd_ready cyc %0d got %0b size %0d", cyc, req_ready, mq.size());
      end
      if (check_local !== (nonempty && issue_en && h.loc)) begin
        errors++; $display("FAIL rnd_local cyc %0d got %0b", cyc, check_local);
      end
      if (check_remote !== (nonempty && issue_en && !h.loc)) begin
        errors++; $display("FAIL rnd_remote cyc %0d got %0b", cyc, check_remote);
      end
      if (level_o !== h.lvl || id_o !== h.id || sd_o !== h.sd) begin
        errors++; $display("FAIL rnd_head cyc %0d got %0d/%0d/%0d want %0d/%0d/%0d",
                           cyc, level_o, id_o, sd_o, h.lvl, h.id, h.sd);
      end
      if (replay_cnt !== 8'(m_replay)) begin
        errors++; $display("FAIL rnd_replay cyc %0d got %0d want %0d", cyc, replay_cnt, m_replay);
      end
      if (drop_cnt !== 8'(m_drop)) begin
        errors++; $display("FAIL rnd_drop cyc %0d got %0d want %0d", cyc, drop_cnt, m_drop);
      end
      tick();
    end
    idle();
  endtask

  initial begin
    @(posedge clk);
    #1;
    test_reset();
    test_single();
    test_fill();
    test_bypass();
    test_ignore_priority();
    test_push_bypass();
    test_reset_mid();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/fractal_sync_1d_req_queue.md
# fractal_sync_1d_req_queue

Per-port request queue that sits directly upstream of the 1D fractal-sync register file. It buffers incoming synchronization requests and issues the head entry to the RF as a local or remote check. It then acts on the RF's same-cycle verdict: the entry is consumed, dropped on ignore, or recirculated to the tail on bypass. One instance is placed per RF port.

## Interface
Parameters:
- FIFO_DEPTH, 4: number of entries; must be ≥ 2.
- LEVEL_WIDTH, 1: width of the level field.
- ID_WIDTH, 1: width of the barrier id field.
- SD_WIDTH, 2: width of the src/dst field.
- CNT_WIDTH, $clog2(FIFO_DEPTH+1): width of the occupancy count (derived; do not override).

Ports:
- clk_i, in, 1: clock. One clock domain; all state updates on the rising edge.
- rst_i, in, 1: reset, synchronous, active-high.
- req_valid_i, in, 1: incoming request valid.
- req_ready_o, out, 1: queue can accept a request this cycle.
- req_level_i, in, LEVEL_WIDTH: request level.
- req_id_i, in, ID_WIDTH: request barrier id.
- req_sd_i, in, SD_WIDTH: request sources.
- req_local_i, in, 1: 1 = local RF check, 0 = remote RF check.
- level_o, out, LEVEL_WIDTH: head level, to the RF.
- id_o, out, ID_WIDTH: head id, to the RF.
- sd_o, out, SD_WIDTH: head src/dst, to the RF.
- check_local_o, out, 1: head issued as a local check.
- check_remote_o, out, 1: head issued as a remote check.
- issue_en_i, in, 1: permits issue this cycle. 0 stalls the head without losing it.
- bypass_i, in, 1: RF verdict for the issued head (the port's local or remote bypass, already selected).
- ignore_i, in, 1: RF verdict for the issued head (ignore).
- count_o, out, CNT_WIDTH: current occupancy.
- empty_o, out, 1: count_o == 0.
- full_o, out, 1: count_o == FIFO_DEPTH.
- replay_cnt_o, out, 8: number of bypass recirculations. Wraps modulo 256.
- drop_cnt_o, out, 8: number of ignored entries dropped. Wraps modulo 256.

## Operation
- Storage: circular buffer of {level, id, sd, local} entries, with head pointer rd_ptr, tail pointer wr_ptr and count register.
  - Pointers advance modulo FIFO_DEPTH, wrapping from FIFO_DEPTH-1 to 0; FIFO_DEPTH need not be a power of two.
- Issue: issue = !empty_o && issue_en_i.
  - check_local_o = issue && head.local.
  - check_remote_o = issue && !head.local.
  - level_o, id_o and sd_o show the head fields when !empty_o, and are 0 when empty.
- Verdict is sampled only when issue = 1. Priority: ignore_i > bypass_i > consume.
  - Consume (neither asserted): pop the head.
  - Ignore: pop the head, discard it, increment drop_cnt_o.
  - Bypass: pop the head and write it unchanged at wr_ptr (recirculate), increment replay_cnt_o. Net count change from this action is 0.
  - bypass_i and ignore_i are don't-care when issue = 0: no pop, no counters change.
- Accept: req_ready_o = (count_o < FIFO_DEPTH), derived from registered count only. Push happens when req_valid_i && req_ready_o.
- Simultaneous push and bypass: the recirculated entry is written at wr_ptr and the new request at wr_ptr+1, so wr_ptr advances by 2.
  - Count changes by +1, which is legal because ready implies count < FIFO_DEPTH.
- Simultaneous push and consume/ignore: count is unchanged.
- Push only: count +1. Pop only: count −1.
- Full and bypass: no input accepted (req_ready_o = 0); the recirculation alone is legal.
- Ordering: apart from recirculation, entries leave in arrival order. A recirculated entry goes behind every entry already present, and ahead of any same-cycle new request.

## Timing
- Reset (rst_i high at a clock edge): rd_ptr, wr_ptr, count, replay_cnt_o and drop_cnt_o all go to 0.
  - Resulting outputs: empty_o = 1, full_o = 0, req_ready_o = 1, check_local_o = check_remote_o = 0, level_o = id_o = sd_o = 0.
  - Reset overrides a push or pop in the same cycle. Entries in flight are lost and no verdict is applied.
- Issue outputs are combinational from head storage, count and issue_en_i. The verdict inputs are combinational from the RF in the same cycle.
- Queue latency: a request pushed at edge N is visible as head no earlier than after edge N; there is no fall-through. Minimum push-to-issue latency is 1 cycle.
- A bypassed single entry is re-issued in the very next cycle.
- Counter updates take effect at the edge that applies the verdict.

## Test plan
- Reset, then push id 1 (local): count_o 0→1; next cycle check_local_o = 1, id_o = 1. Verdict none → count_o 0, empty_o = 1.
- Fill with ids 0,1,2,3, consuming nothing (issue_en_i = 0): full_o = 1, req_ready_o = 0, a 5th push is rejected. Drain with no verdict → issue order 0,1,2,3, then both pointers back at 0.
- Queue ids 5,6. Assert bypass_i on 5 → issue order 5,6,5; replay_cnt_o = 1; count_o goes 2,2,1.
- Assert ignore_i and bypass_i together on id 2 → entry dropped, drop_cnt_o = 1, replay_cnt_o unchanged.
- Count = 3 with FIFO_DEPTH = 4: bypass head id 7 while pushing id 9 → count_o = 4, tail order …,7,9. Same with count = 4 → input rejected, count_o stays 4.
- Push two entries, then assert rst_i for one cycle mid-stream → all outputs at reset values on the following cycle, replay_cnt_o = drop_cnt_o = 0.
